// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive engine: state encoding, data-length
// codes, oversample tick positions and the character right-justify helper.
package uart_rx_pkg;

   localparam logic [2:0] ENC_IDLE   = 3'd0;
   localparam logic [2:0] ENC_START  = 3'd1;
   localparam logic [2:0] ENC_DATA   = 3'd2;
   localparam logic [2:0] ENC_PARITY = 3'd3;
   localparam logic [2:0] ENC_STOP   = 3'd4;

   typedef enum logic [2:0] {
      IDLE   = ENC_IDLE,
      START  = ENC_START,
      DATA   = ENC_DATA,
      PARITY = ENC_PARITY,
      STOP   = ENC_STOP
   } rx_state_t;

   localparam logic [1:0] LEN_5 = 2'b00;
   localparam logic [1:0] LEN_6 = 2'b01;
   localparam logic [1:0] LEN_7 = 2'b10;
   localparam logic [1:0] LEN_8 = 2'b11;

   localparam logic [3:0] START_SAMPLE_TICK = 4'd7;
   localparam logic [3:0] BIT_SAMPLE_TICK   = 4'd15;

   // Data enters the shift register at the MSB, so a short character sits in
   // the upper bits and must be moved down by the number of unused bits.
   function automatic logic [7:0] right_justify(input logic [7:0] shift,
                                                input logic [1:0] len);
      logic [1:0] gap;
      gap = LEN_8 - len;
      return shift >> gap;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous serial line; resets to the
// idle (high) level so a reset never looks like a start bit.
module uart_rx_sync
   import uart_rx_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic sys_clk,
   input  logic rst_b,
   input  logic async_in,
   output logic sync_out
);

   logic [SYNC_STAGES-1:0] stages;

   always_ff @(posedge sys_clk or negedge rst_b) begin
      if (!rst_b) begin
         stages <= '1;
      end else begin
         stages <= {stages[SYNC_STAGES-2:0], async_in};
      end
   end

   assign sync_out = stages[SYNC_STAGES-1];

endmodule

// File: rtl/uart_receive_core.sv
// 16x-oversampling UART receiver: start-bit qualification, 5-8 data bits,
// optional parity, one checked stop bit, and a single-entry holding register.
module uart_receive_core
   import uart_rx_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       sys_clk,
   input  logic       rst_b,
   input  logic       receive_clk_en,
   input  logic       uart_rxd,
   input  logic [1:0] ctrl_data_len,
   input  logic       ctrl_parity_en,
   input  logic       ctrl_parity_even,
   input  logic       rbr_read,
   output logic [7:0] rx_data,
   output logic       rx_data_vld,
   output logic       rx_parity_err,
   output logic       rx_frame_err,
   output logic       rx_overrun_err,
   output logic       rx_busy
);

   logic       rxd_s;
   rx_state_t  state;
   logic [3:0] tick_cnt;
   logic [2:0] bit_cnt;
   logic [7:0] shift_reg;
   logic [1:0] frame_len;
   logic       frame_par_en;
   logic       frame_par_even;
   logic       frame_perr;
   logic [2:0] last_bit;

   uart_rx_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .sys_clk (sys_clk),
      .rst_b   (rst_b),
      .async_in(uart_rxd),
      .sync_out(rxd_s)
   );

   assign last_bit = 3'd4 + {1'b0, frame_len};

   // The read strobe clears the holding register first; a completion on the
   // same cycle overrides it, so a coincident read hands over the new character.
   always_ff @(posedge sys_clk or negedge rst_b) begin
      if (!rst_b) begin
         state          <= IDLE;
         tick_cnt       <= '0;
         bit_cnt        <= '0;
         shift_reg      <= '0;
         frame_len      <= LEN_8;
         frame_par_en   <= 1'b0;
         frame_par_even <= 1'b0;
         frame_perr     <= 1'b0;
         rx_data        <= '0;
         rx_data_vld    <= 1'b0;
         rx_parity_err  <= 1'b0;
         rx_frame_err   <= 1'b0;
         rx_overrun_err <= 1'b0;
         rx_busy        <= 1'b0;
      end else begin
         if (rbr_read) begin
            rx_data_vld    <= 1'b0;
            rx_parity_err  <= 1'b0;
            rx_frame_err   <= 1'b0;
            rx_overrun_err <= 1'b0;
         end
         if (receive_clk_en) begin
            tick_cnt <= tick_cnt + 4'd1;
            unique case (state)
               IDLE: begin
                  if (!rxd_s) begin
                     state          <= START;
                     tick_cnt       <= '0;
                     frame_len      <= ctrl_data_len;
                     frame_par_en   <= ctrl_parity_en;
                     frame_par_even <= ctrl_parity_even;
                     rx_busy        <= 1'b1;
                  end
               end
               START: begin
                  if (tick_cnt == START_SAMPLE_TICK) begin
                     if (!rxd_s) begin
                        state      <= DATA;
                        tick_cnt   <= '0;
                        bit_cnt    <= '0;
                        shift_reg  <= '0;
                        frame_perr <= 1'b0;
                     end else begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                     end
                  end
               end
               DATA: begin
                  if (tick_cnt == BIT_SAMPLE_TICK) begin
                     shift_reg <= {rxd_s, shift_reg[7:1]};
                     bit_cnt   <= bit_cnt + 3'd1;
                     if (bit_cnt == last_bit) begin
                        state <= frame_par_en ? PARITY : STOP;
                     end
                  end
               end
               PARITY: begin
                  if (tick_cnt == BIT_SAMPLE_TICK) begin
                     frame_perr <= (^shift_reg) ^ rxd_s ^ ~frame_par_even;
                     state      <= STOP;
                  end
               end
               STOP: begin
                  if (tick_cnt == BIT_SAMPLE_TICK) begin
                     state   <= IDLE;
                     rx_busy <= 1'b0;
                     if (!rx_data_vld || rbr_read) begin
                        rx_data        <= right_justify(shift_reg, frame_len);
                        rx_data_vld    <= 1'b1;
                        rx_parity_err  <= frame_perr;
                        rx_frame_err   <= ~rxd_s;
                        rx_overrun_err <= 1'b0;
                     end else begin
                        rx_overrun_err <= 1'b1;
                     end
                  end
               end
               default: begin
                  state   <= IDLE;
                  rx_busy <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_receive_core.sv
// Directed bench for uart_receive_core: serial frames are driven bit by bit,
// expected characters are queued as each frame is sent and popped on output.
module tb_uart_receive_core;
   import uart_rx_pkg::*;

   logic       sys_clk = 1'b0;
   logic       rst_b = 1'b0;
   logic       receive_clk_en = 1'b0;
   logic       uart_rxd = 1'b1;
   logic [1:0] ctrl_data_len = LEN_8;
   logic       ctrl_parity_en = 1'b0;
   logic       ctrl_parity_even = 1'b0;
   logic       rbr_read = 1'b0;
   logic [7:0] rx_data;
   logic       rx_data_vld;
   logic       rx_parity_err;
   logic       rx_frame_err;
   logic       rx_overrun_err;
   logic       rx_busy;

   typedef struct packed {
      logic [7:0] data;
      logic       vld;
      logic       perr;
      logic       ferr;
      logic       ovr;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   div = 16;
   int   div_cnt = 0;

   uart_receive_core #(
      .SYNC_STAGES(2)
   ) dut (
      .sys_clk         (sys_clk),
      .rst_b           (rst_b),
      .receive_clk_en  (receive_clk_en),
      .uart_rxd        (uart_rxd),
      .ctrl_data_len   (ctrl_data_len),
      .ctrl_parity_en  (ctrl_parity_en),
      .ctrl_parity_even(ctrl_parity_even),
      .rbr_read        (rbr_read),
      .rx_data         (rx_data),
      .rx_data_vld     (rx_data_vld),
      .rx_parity_err   (rx_parity_err),
      .rx_frame_err    (rx_frame_err),
      .rx_overrun_err  (rx_overrun_err),
      .rx_busy         (rx_busy)
   );

   always #5 sys_clk = ~sys_clk;

   // Baud-generator stand-in: one-cycle tick every 'div' clocks, stuck high at 1.
   always @(negedge sys_clk) begin
      if (div == 0) begin
         receive_clk_en = 1'b0;
      end else if (div == 1) begin
         receive_clk_en = 1'b1;
      end else begin
         div_cnt = div_cnt + 1;
         if (div_cnt >= div) begin
            div_cnt = 0;
            receive_clk_en = 1'b1;
         end else begin
            receive_clk_en = 1'b0;
         end
      end
   end

   task automatic check_field(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_bit(input logic b);
      uart_rxd = b;
      repeat (16 * div) @(negedge sys_clk);
   endtask

   task automatic idle_bits(input int n);
      uart_rxd = 1'b1;
      repeat (n) drive_bit(1'b1);
   endtask

   task automatic apply_stimulus(input logic [7:0] data, input int nbits, input logic par_en,
                                 input logic par_even, input logic bad_par, input logic stop_val);
      logic p;
      p = 1'b0;
      drive_bit(1'b0);
      for (int i = 0; i < nbits; i++) begin
         drive_bit(data[i]);
         p = p ^ data[i];
      end
      if (par_en) drive_bit((par_even ? p : ~p) ^ bad_par);
      drive_bit(stop_val);
      uart_rxd = 1'b1;
   endtask

   task automatic push_exp(input logic [7:0] d, input logic v, input logic pe,
                           input logic fe, input logic ov);
      exp_t e;
      e.data = d;
      e.vld  = v;
      e.perr = pe;
      e.ferr = fe;
      e.ovr  = ov;
      sb.push_back(e);
   endtask

   task automatic check_output(input string tag);
      exp_t e;
      int   waited;
      waited = 0;
      @(negedge sys_clk);
      #1;
      while (!rx_data_vld && waited < 64 * div) begin
         @(negedge sys_clk);
         #1;
         waited++;
      end
      checks++;
      assert (sb.size() > 0) else begin
         errors++;
         $error("[TB] FAIL %s_sb: observed empty scoreboard expected entry", tag);
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check_field({tag, "_data"}, rx_data, e.data);
         check_field({tag, "_vld"}, {7'd0, rx_data_vld}, {7'd0, e.vld});
         check_field({tag, "_perr"}, {7'd0, rx_parity_err}, {7'd0, e.perr});
         check_field({tag, "_ferr"}, {7'd0, rx_frame_err}, {7'd0, e.ferr});
         check_field({tag, "_ovr"}, {7'd0, rx_overrun_err}, {7'd0, e.ovr});
      end
   endtask

   task automatic read_and_check(input string tag);
      @(negedge sys_clk);
      rbr_read = 1'b1;
      @(negedge sys_clk);
      rbr_read = 1'b0;
      #1;
      check_field({tag, "_rd_vld"}, {7'd0, rx_data_vld}, 8'd0);
      check_field({tag, "_rd_flags"}, {5'd0, rx_parity_err, rx_frame_err, rx_overrun_err}, 8'd0);
   endtask

   task automatic check_reset_values(input string tag);
      check_field({tag, "_data"}, rx_data, 8'h00);
      check_field({tag, "_flags"}, {3'd0, rx_data_vld, rx_parity_err, rx_frame_err,
                                    rx_overrun_err, rx_busy}, 8'd0);
   endtask

   task automatic reset_mid_frame(input string tag);
      drive_bit(1'b0);
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      uart_rxd = 1'b1;
      repeat (8 * div) @(negedge sys_clk);
      rst_b = 1'b0;
      #1;
      check_reset_values(tag);
      repeat (4) @(negedge sys_clk);
      rst_b = 1'b1;
      idle_bits(2);
   endtask

   initial begin
      logic busy_seen;
      logic hit;
      int   guard;

      $display("[TB] start");
      repeat (3) @(negedge sys_clk);
      #1;
      check_reset_values("reset");
      rst_b = 1'b1;
      idle_bits(2);

      // 8N1 0xA5
      ctrl_data_len = LEN_8;
      ctrl_parity_en = 1'b0;
      push_exp(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
      apply_stimulus(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1);
      check_output("t1");
      read_and_check("t1");
      read_and_check("t1_empty");
      check_field("t1_keep_data", rx_data, 8'hA5);
      idle_bits(1);

      // 7E1 0x35, good then bad parity; control changed mid-frame must be ignored
      ctrl_data_len = LEN_7;
      ctrl_parity_en = 1'b1;
      ctrl_parity_even = 1'b1;
      push_exp(8'h35, 1'b1, 1'b0, 1'b0, 1'b0);
      fork
         apply_stimulus(8'h35, 7, 1'b1, 1'b1, 1'b0, 1'b1);
         begin
            repeat (40 * div) @(negedge sys_clk);
            ctrl_data_len = LEN_5;
            ctrl_parity_en = 1'b0;
         end
      join
      check_output("t2a");
      read_and_check("t2a");
      ctrl_data_len = LEN_7;
      ctrl_parity_en = 1'b1;
      push_exp(8'h35, 1'b1, 1'b1, 1'b0, 1'b0);
      apply_stimulus(8'h35, 7, 1'b1, 1'b1, 1'b1, 1'b1);
      check_output("t2b");
      read_and_check("t2b");
      idle_bits(1);

      // 5O1 0x1F with low stop bit
      ctrl_data_len = LEN_5;
      ctrl_parity_even = 1'b0;
      push_exp(8'h1F, 1'b1, 1'b0, 1'b1, 1'b0);
      apply_stimulus(8'h1F, 5, 1'b1, 1'b0, 1'b0, 1'b0);
      check_output("t3");
      idle_bits(3);
      check_field("t3_idle", {7'd0, rx_busy}, 8'd0);
      read_and_check("t3");

      // four-tick low glitch must be rejected as a false start
      busy_seen = 1'b0;
      uart_rxd = 1'b0;
      repeat (4 * div) @(negedge sys_clk);
      uart_rxd = 1'b1;
      repeat (40 * div) begin
         @(negedge sys_clk);
         #1;
         if (rx_busy) busy_seen = 1'b1;
      end
      check_field("t4_busy_pulse", {7'd0, busy_seen}, 8'd1);
      check_field("t4_busy_end", {7'd0, rx_busy}, 8'd0);
      check_field("t4_vld", {7'd0, rx_data_vld}, 8'd0);

      // back-to-back 8N1 frames without reading -> overrun keeps first character
      ctrl_data_len = LEN_8;
      ctrl_parity_en = 1'b0;
      push_exp(8'h11, 1'b1, 1'b0, 1'b0, 1'b1);
      apply_stimulus(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b1);
      apply_stimulus(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b1);
      check_output("t5a");
      idle_bits(1);

      // read strobe on the very cycle the third frame completes
      push_exp(8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
      hit = 1'b0;
      fork
         apply_stimulus(8'h33, 8, 1'b0, 1'b0, 1'b0, 1'b1);
         begin
            guard = 0;
            while (!hit && guard < 20000) begin
               @(negedge sys_clk);
               #1;
               guard++;
               if (dut.state == STOP && dut.tick_cnt == BIT_SAMPLE_TICK && receive_clk_en) begin
                  rbr_read = 1'b1;
                  @(negedge sys_clk);
                  rbr_read = 1'b0;
                  hit = 1'b1;
               end
            end
         end
      join
      check_field("t5_coincident_read", {7'd0, hit}, 8'd1);
      check_output("t5b");

      // reset during data bit 3 with an unread character held, then clean frame
      reset_mid_frame("t6_rst");
      push_exp(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
      apply_stimulus(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1);
      check_output("t6");

      // same again with the tick held permanently high
      div = 1;
      idle_bits(2);
      reset_mid_frame("t6h_rst");
      push_exp(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
      apply_stimulus(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1);
      check_output("t6h");
      read_and_check("t6h");

      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("[TB] FAIL sb_drain: observed %0d entries expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
